// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: serialises a 16-bit mono sample as I2S left/right frames for the codec DAC
module i2s_dac_tx #(
  parameter int DW      = 16,
  parameter int CLK_DIV = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Enable,
  input  logic [DW-1:0] music_data,
  output logic          data_over,
  output logic          AUD_BCLK,
  output logic          AUD_DACLRCK,
  output logic          AUD_DACDAT
);
  localparam int FW = 2 * DW;
  localparam int CW = $clog2(CLK_DIV);
  localparam int SW = $clog2(FW);
  typedef enum logic {IDLE, RUN} state_t;
  state_t          state, state_nxt;
  logic [CW-1:0]   div_cnt;
  logic [SW-1:0]   slot, slot_n;
  logic [FW-1:0]   sh, tx;
  logic            prev_lsb, div_wrap, fall, fs;
  always_comb begin
    state_nxt = Enable ? RUN : IDLE;
    div_wrap  = div_cnt == CW'(CLK_DIV - 1);
    fall      = div_wrap && AUD_BCLK;
    slot_n    = slot + 1'b1;
    fs        = Enable && (state == IDLE || (fall && slot == SW'(FW - 1)));
    // one-slot I2S delay: previous LSB leads, right channel drops its LSB into the next frame
    tx        = {prev_lsb, music_data, music_data[DW-1:1]};
  end
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : state_nxt;
  always_ff @(posedge Clk) begin
    if (Reset || !Enable) begin
      div_cnt     <= '0;
      slot        <= '0;
      sh          <= '0;
      prev_lsb    <= 1'b0;
      data_over   <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
    end else if (fs) begin
      div_cnt     <= '0;
      slot        <= '0;
      sh          <= tx;
      prev_lsb    <= music_data[0];
      data_over   <= 1'b1;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= tx[FW-1];
    end else begin
      data_over <= 1'b0;
      div_cnt   <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap)
        AUD_BCLK <= ~AUD_BCLK;
      if (fall) begin
        slot        <= slot_n;
        sh          <= sh << 1;
        AUD_DACDAT  <= sh[FW-2];
        AUD_DACLRCK <= slot_n >= SW'(DW);
      end
    end
  end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed checks of I2S framing, timing, enable and reset behaviour at CLK_DIV=4
module tb_i2s_dac_tx;
  logic        Clk = 0, Reset = 1, Enable = 0;
  logic [15:0] music_data = '0;
  logic        data_over, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;
  int          n_chk = 0, n_err = 0;

  i2s_dac_tx #(.DW(16), .CLK_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .music_data(music_data),
    .data_over(data_over), .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, data_over, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT};
  endfunction

  // called in the first cycle of a frame; walks all 256 cycles, changing music_data at cycle 10
  task automatic run_frame(input string tag, input logic [15:0] md_mid, input logic [31:0] exp_dat);
    logic [31:0] dat = '0, lr = '0;
    logic        d0 = 0, l0 = 0;
    int          bad = 0;
    for (int c = 0; c < 256; c++) begin
      if (c > 0) tick();
      if (c == 10) music_data = md_mid;
      if (AUD_BCLK !== ((c % 8) >= 4)) bad++;
      if (data_over !== (c == 0)) bad++;
      if (c % 8 == 0) begin
        d0 = AUD_DACDAT;
        l0 = AUD_DACLRCK;
        dat[31 - c / 8] = AUD_DACDAT;
        lr[31 - c / 8]  = AUD_DACLRCK;
      end else if (AUD_DACDAT !== d0 || AUD_DACLRCK !== l0) bad++;
    end
    check({tag, "_dat"}, dat, exp_dat);
    check({tag, "_lrck"}, lr, 32'h0000FFFF);
    check({tag, "_timing"}, bad, 0);
  endtask

  logic [15:0] md_tab [5] = '{16'h0001, 16'h8000, 16'h1234, 16'h1234, 16'hFFFF};
  logic [31:0] ex_tab [5] = '{32'h52E1D2E1, 32'h80008000, 32'hC0004000, 32'h091A091A, 32'h091A091A};

  initial begin
    int act = 0;
    repeat (3) tick();
    check("t1_reset", outs(), 0);
    Reset = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      act += int'(outs() != 0);
    end
    check("t1_idle_quiet", act, 0);

    music_data = 16'hA5C3;
    Enable = 1;
    tick();
    check("t2_first_run", outs(), 32'h8);
    for (int f = 0; f < 5; f++) begin
      if (f > 0) tick();
      run_frame($sformatf("frame%0d", f), md_tab[f], ex_tab[f]);
    end

    tick();
    check("t5_fs", outs(), 32'h8);
    repeat (80) tick();
    check("t5_slot10", outs(), 32'h1);
    Enable = 0;
    tick();
    check("t5_drop", outs(), 0);
    repeat (5) tick();
    check("t5_idle", outs(), 0);
    Enable = 1;
    tick();
    run_frame("t5_reen", 16'hFFFF, 32'h7FFFFFFF);

    tick();
    check("t6_fs", outs(), 32'h9);
    repeat (50) tick();
    Reset = 1;
    tick();
    check("t6_reset", outs(), 0);
    music_data = 16'h0F0F;
    Reset = 0;
    tick();
    run_frame("t6_restart", 16'h0F0F, 32'h07878787);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
